gmii_tx_arbiter_host: RTL and testbench

- Shares one GMII transmit port toward the host PHY between two frame sources: ch0, the TSN switch egress, and ch1, the local management/PTP frame injector.
- Uses a req/grant handshake with frame-granular arbitration and selectable fixed or round-robin priority.
- Enforces the inter-frame gap, a grant-to-start timeout, and a maximum frame length.
- Sits between the switch/injector outputs and the host-side GMII adapter TX path, in the gmii_txclk domain.

---
 rtl/gmii_tx_arbiter_host.sv | 188 ++++++++++++++++++
 tb/tb_gmii_tx_arbiter_host.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/gmii_tx_arbiter_host.sv
// Frame-granular arbiter sharing one GMII TX port between the TSN switch egress (ch0)
// and the management/PTP injector (ch1), with IFG, grant timeout and length cap enforcement.
module gmii_tx_arbiter_host #(
  parameter int unsigned IFG_CYCLES    = 12,
  parameter int unsigned GRANT_TIMEOUT = 64,
  parameter int unsigned MAX_FRAME_CYC = 1530,
  parameter bit          RR_EN         = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  output logic       grant0,
  input  logic       dv0,
  input  logic       er0,
  input  logic [7:0] d0,
  input  logic       req1,
  output logic       grant1,
  input  logic       dv1,
  input  logic       er1,
  input  logic [7:0] d1,
  output logic       gmii_tx_en,
  output logic       gmii_tx_er,
  output logic [7:0] gmii_txd,
  output logic       trunc_pulse,
  output logic       timeout_pulse,
  output logic [2:0] dbg_state_o
);

  localparam int TW = $clog2(GRANT_TIMEOUT) + 1;
  localparam int LW = $clog2(MAX_FRAME_CYC) + 1;
  localparam int IW = $clog2(IFG_CYCLES) + 1;

  localparam logic [TW-1:0] TMO_LAST = TW'(GRANT_TIMEOUT - 1);
  localparam logic [LW-1:0] LEN_LAST = LW'(MAX_FRAME_CYC - 1);
  localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_FRAME_CYC);
  localparam logic [IW-1:0] IFG_LAST = IW'(IFG_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GRANT = 3'd1,
    S_XMIT  = 3'd2,
    S_DRAIN = 3'd3,
    S_IFG   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic            sel_ch_q, sel_ch_d;
  logic            gnt_q, gnt_d;
  logic            rr_last_q, rr_last_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [LW-1:0]   len_q, len_d;
  logic [IW-1:0]   ifg_q, ifg_d;
  logic            tx_en_q, tx_en_d;
  logic            tx_er_q, tx_er_d;
  logic [7:0]      txd_q, txd_d;
  logic            trunc_q, trunc_d;
  logic            timeout_q, timeout_d;

  logic            sel_req, sel_dv, sel_er, win_ch;
  logic [7:0]      sel_txd;

  // Handshake: a source holds req until it sees grant; while granted it owns dv/er/d, and
  // the frame ends when its dv falls. Inputs of the other channel never reach the output.
  assign sel_req = sel_ch_q ? req1 : req0;
  assign sel_dv  = sel_ch_q ? dv1  : dv0;
  assign sel_er  = sel_ch_q ? er1  : er0;
  assign sel_txd = sel_ch_q ? d1   : d0;

  // Tie goes to the channel not served last (round-robin) or to ch0 (fixed).
  assign win_ch = (req1 && !req0) || (req0 && req1 && RR_EN && !rr_last_q);

  always_comb begin
    state_d   = state_q;
    sel_ch_d  = sel_ch_q;
    gnt_d     = gnt_q;
    rr_last_d = rr_last_q;
    timer_d   = timer_q;
    len_d     = len_q;
    ifg_d     = ifg_q;
    tx_en_d   = 1'b0;
    tx_er_d   = 1'b0;
    txd_d     = 8'h00;
    trunc_d   = 1'b0;
    timeout_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          sel_ch_d = win_ch;
          gnt_d    = 1'b1;
          timer_d  = '0;
          state_d  = S_GRANT;
        end
      end
      S_GRANT: begin
        if (sel_dv) begin
          tx_en_d = 1'b1;
          tx_er_d = sel_er;
          txd_d   = sel_txd;
          len_d   = LW'(1);
          state_d = S_XMIT;
        end else if (!sel_req) begin
          gnt_d   = 1'b0;
          ifg_d   = '0;
          state_d = S_IFG;
        end else if (timer_q == TMO_LAST) begin
          gnt_d     = 1'b0;
          timeout_d = 1'b1;
          ifg_d     = '0;
          state_d   = S_IFG;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_XMIT: begin
        if (!sel_dv) begin
          gnt_d     = 1'b0;
          rr_last_d = sel_ch_q;
          ifg_d     = '0;
          state_d   = S_IFG;
        end else begin
          tx_en_d = 1'b1;
          tx_er_d = sel_er;
          txd_d   = sel_txd;
          // The cycle that hits the length cap goes out poisoned with er.
          if (len_q == LEN_LAST) begin
            tx_er_d = 1'b1;
            trunc_d = 1'b1;
            state_d = S_DRAIN;
          end
          if (len_q != LEN_MAX) len_d = len_q + LW'(1);
        end
      end
      S_DRAIN: begin
        if (!sel_dv) begin
          gnt_d     = 1'b0;
          rr_last_d = sel_ch_q;
          ifg_d     = '0;
          state_d   = S_IFG;
        end
      end
      S_IFG: begin
        if (ifg_q == IFG_LAST) state_d = S_IDLE;
        else                   ifg_d   = ifg_q + IW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sel_ch_q  <= 1'b0;
      gnt_q     <= 1'b0;
      rr_last_q <= 1'b1;
      timer_q   <= '0;
      len_q     <= '0;
      ifg_q     <= '0;
      tx_en_q   <= 1'b0;
      tx_er_q   <= 1'b0;
      txd_q     <= 8'h00;
      trunc_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_ch_q  <= sel_ch_d;
      gnt_q     <= gnt_d;
      rr_last_q <= rr_last_d;
      timer_q   <= timer_d;
      len_q     <= len_d;
      ifg_q     <= ifg_d;
      tx_en_q   <= tx_en_d;
      tx_er_q   <= tx_er_d;
      txd_q     <= txd_d;
      trunc_q   <= trunc_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant0        = gnt_q & ~sel_ch_q;
  assign grant1        = gnt_q & sel_ch_q;
  assign gmii_tx_en    = tx_en_q;
  assign gmii_tx_er    = tx_er_q;
  assign gmii_txd      = txd_q;
  assign trunc_pulse   = trunc_q;
  assign timeout_pulse = timeout_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_gmii_tx_arbiter_host.sv
// Directed bench for gmii_tx_arbiter_host: reset, single frame and IFG, round-robin and
// fixed-priority order, isolation, grant timeout, truncation and reset mid-frame.
module tb_gmii_tx_arbiter_host;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, dv0, er0, req1, dv1, er1;
  logic [7:0] d0, d1;
  logic       grant0, grant1, gmii_tx_en, gmii_tx_er, trunc_pulse, timeout_pulse;
  logic [7:0] gmii_txd;
  logic [2:0] dbg_state;

  logic       fp_req0, fp_req1, fp_dv0, fp_dv1;
  logic       fp_grant0, fp_grant1, fp_tx_en, fp_tx_er, fp_trunc, fp_timeout;
  logic [7:0] fp_txd;
  logic [2:0] fp_state;

  logic [8:0] exp_q[$];
  int         n_checks = 0;
  int         n_pass = 0;
  int         cyc = 0;
  int         n_trunc = 0;
  int         n_tmo = 0;
  int         n_aa = 0;
  bit         watch_aa = 1'b0;

  always #5 clk = ~clk;

  gmii_tx_arbiter_host dut (
    .clk(clk), .rst(rst),
    .req0(req0), .grant0(grant0), .dv0(dv0), .er0(er0), .d0(d0),
    .req1(req1), .grant1(grant1), .dv1(dv1), .er1(er1), .d1(d1),
    .gmii_tx_en(gmii_tx_en), .gmii_tx_er(gmii_tx_er), .gmii_txd(gmii_txd),
    .trunc_pulse(trunc_pulse), .timeout_pulse(timeout_pulse), .dbg_state_o(dbg_state)
  );

  gmii_tx_arbiter_host #(.RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst(rst),
    .req0(fp_req0), .grant0(fp_grant0), .dv0(fp_dv0), .er0(1'b0), .d0(8'h55),
    .req1(fp_req1), .grant1(fp_grant1), .dv1(fp_dv1), .er1(1'b0), .d1(8'h66),
    .gmii_tx_en(fp_tx_en), .gmii_tx_er(fp_tx_er), .gmii_txd(fp_txd),
    .trunc_pulse(fp_trunc), .timeout_pulse(fp_timeout), .dbg_state_o(fp_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // One clock, then the output monitor/scoreboard.
  task automatic step();
    logic [8:0] e;
    @(posedge clk);
    #1;
    cyc++;
    if (trunc_pulse) n_trunc++;
    if (timeout_pulse) n_tmo++;
    if (watch_aa && gmii_tx_en && gmii_txd == 8'hAA) n_aa++;
    if (grant0 && grant1) check("grant_onehot", 32'd1, 32'd0);
    if (gmii_tx_en) begin
      if (exp_q.size() == 0) begin
        check("unexpected_tx_en", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("tx_data", 32'({gmii_tx_er, gmii_txd}), 32'(e));
      end
    end
  endtask

  task automatic wait_grant(input int max_cyc, output int ch, output int waited);
    waited = 0;
    ch = -1;
    while (!(grant0 || grant1) && waited < max_cyc) begin
      step();
      waited++;
    end
    if (grant0 || grant1) ch = grant1 ? 1 : 0;
    else check("grant_wait_expired", 32'd0, 32'd1);
  endtask

  // Granted channel sends len bytes; the other channel drives dv with 0xAA meanwhile.
  task automatic send_frame(input int ch, input int len);
    logic [7:0] data;
    watch_aa = 1'b1;
    for (int i = 0; i < len; i++) begin
      data = (ch == 1) ? (8'hC0 + 8'(i)) : (8'h10 + 8'(i));
      if (ch == 1) begin
        dv1 = 1'b1; d1 = data; dv0 = 1'b1; d0 = 8'hAA;
      end else begin
        dv0 = 1'b1; d0 = data; dv1 = 1'b1; d1 = 8'hAA;
      end
      exp_q.push_back({1'b0, data});
      step();
    end
    dv0 = 1'b0; dv1 = 1'b0; d0 = 8'h00; d1 = 8'h00;
    step();
    check("grant_falls_with_dv", 32'(grant0 | grant1), 32'd0);
    check("frame_fully_output", 32'(exp_q.size()), 32'd0);
    watch_aa = 1'b0;
  endtask

  initial begin
    int ch, waited, n, chan;
    rst = 1'b1;
    req0 = 1'b0; dv0 = 1'b0; er0 = 1'b0; d0 = 8'h00;
    req1 = 1'b0; dv1 = 1'b0; er1 = 1'b0; d1 = 8'h00;
    fp_req0 = 1'b0; fp_req1 = 1'b0; fp_dv0 = 1'b0; fp_dv1 = 1'b0;
    repeat (3) step();
    check("rst_outputs", 32'({gmii_tx_en, gmii_tx_er, gmii_txd, trunc_pulse, timeout_pulse}), 32'd0);
    check("rst_grants", 32'({grant0, grant1}), 32'd0);
    check("rst_state_idle", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    step();

    // Single ch0 frame, 1-cycle grant latency, dv starts 3 cycles after grant
    req0 = 1'b1;
    step();
    check("req_grant_latency", 32'(grant0), 32'd1);
    repeat (2) step();
    send_frame(0, 72);
    wait_grant(40, ch, waited);
    check("ifg_regrant_ch", 32'(ch), 32'd0);
    check("ifg_regrant_gap", 32'(waited), 32'd13);

    // Round-robin: ch0 already holds the grant, then ch1, ch0, ch1
    req1 = 1'b1;
    send_frame(0, 64);
    for (int k = 1; k < 4; k++) begin
      wait_grant(40, ch, waited);
      check("rr_order", 32'(ch), 32'(k % 2));
      check("rr_gap", 32'(waited), 32'd13);
      send_frame((k % 2), 64);
    end
    check("isolation_no_aa", 32'(n_aa), 32'd0);

    // Grant timeout on ch1; ch0 requests meanwhile and wins afterwards
    req0 = 1'b0;
    wait_grant(40, ch, waited);
    check("tmo_grant_ch1", 32'(ch), 32'd1);
    req0 = 1'b1;
    n = 0;
    while (grant1 && n < 100) begin
      step();
      n++;
    end
    check("tmo_grant_len", 32'(n), 32'd64);
    check("tmo_pulse_high", 32'(timeout_pulse), 32'd1);
    step();
    check("tmo_pulse_one_cycle", 32'(timeout_pulse), 32'd0);
    wait_grant(40, ch, waited);
    check("tmo_then_ch0", 32'(ch), 32'd0);
    check("tmo_ifg_gap", 32'(waited), 32'd12);
    req1 = 1'b0;

    // Truncation: 1600 dv cycles, cycle 1530 goes out with er, rest suppressed
    for (int i = 1; i <= 1600; i++) begin
      dv0 = 1'b1;
      d0 = 8'(i);
      if (i <= 1530) exp_q.push_back({(i == 1530), 8'(i)});
      step();
      if (i == 1530) begin
        check("trunc_er", 32'(gmii_tx_er), 32'd1);
        check("trunc_pulse", 32'(trunc_pulse), 32'd1);
      end
      if (i == 1531) check("trunc_suppressed", 32'(gmii_tx_en), 32'd0);
    end
    check("trunc_grant_held", 32'(grant0), 32'd1);
    dv0 = 1'b0;
    step();
    check("trunc_grant_falls", 32'(grant0), 32'd0);
    check("trunc_pulse_count", 32'(n_trunc), 32'd1);
    check("trunc_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset at byte 40 of a 100-byte ch0 frame
    wait_grant(40, ch, waited);
    check("pre_rst_grant", 32'(ch), 32'd0);
    for (int i = 1; i < 40; i++) begin
      dv0 = 1'b1;
      d0 = 8'(i + 100);
      exp_q.push_back({1'b0, 8'(i + 100)});
      step();
    end
    rst = 1'b1;
    dv0 = 1'b0;
    step();
    check("rst_mid_tx_en", 32'({gmii_tx_en, gmii_tx_er}), 32'd0);
    check("rst_mid_grant", 32'({grant0, grant1}), 32'd0);
    check("rst_mid_queue", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    step();
    rst = 1'b0;
    wait_grant(2, ch, waited);
    check("rst_regrant_ch", 32'(ch), 32'd0);
    check("rst_regrant_lat", 32'(waited), 32'd1);
    check("rst_regrant_state", 32'(dbg_state), 32'd1);
    req0 = 1'b0;
    step();
    check("req_drop_release", 32'(grant0), 32'd0);
    check("req_drop_state_ifg", 32'(dbg_state), 32'd4);
    check("req_drop_no_pulse", 32'(timeout_pulse), 32'd0);
    check("tmo_total_pulses", 32'(n_tmo), 32'd1);

    // Fixed priority: ch0 wins every tie
    fp_req0 = 1'b1;
    fp_req1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (!(fp_grant0 || fp_grant1) && n < 40) begin
        @(posedge clk); #1; n++;
      end
      check("fp_grant_seen", 32'(fp_grant0 | fp_grant1), 32'd1);
      chan = fp_grant1 ? 1 : 0;
      check("fp_order", 32'(chan), 32'd0);
      fp_dv0 = (chan == 0);
      fp_dv1 = (chan == 1);
      repeat (8) begin
        @(posedge clk); #1;
      end
      fp_dv0 = 1'b0;
      fp_dv1 = 1'b0;
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
